// File: rtl/zint_pkg.sv
// zint_mux shared definitions: FSM state codes, channel limit,
// and the IM2 vector builder.
package zint_pkg;

    localparam int ZINT_MAXCH = 8;

    typedef logic [1:0] zstate_t;

    localparam zstate_t ST_IDLE    = 2'd0;
    localparam zstate_t ST_ACTIVE  = 2'd1;
    localparam zstate_t ST_ACKWAIT = 2'd2;

    // Channel index replaces bits [3:1] of the base byte.
    function automatic logic [7:0] mk_vector(
        input logic [7:0] base,
        input logic [2:0] chan
    );
        return {base[7:4], chan, base[0]};
    endfunction

endpackage

// File: rtl/zint_mux_if.sv
// Z80 interrupt bus between the CPU-side glue and zint_mux.
// master drives the Z80 strobes and sources; slave is the generator.
interface zint_mux_if #(
    parameter int NCH = 4
) ();

    logic           zpos;
    logic           zneg;
    logic [NCH-1:0] int_start;
    logic [NCH-1:0] int_en;
    logic           iorq_n;
    logic           m1_n;
    logic           int_n;
    logic [7:0]     int_vector;
    logic           int_ack;
    logic [2:0]     ack_chan;
    logic [NCH-1:0] pending;

    modport master (
        output zpos, zneg, int_start, int_en, iorq_n, m1_n,
        input  int_n, int_vector, int_ack, ack_chan, pending
    );

    modport slave (
        input  zpos, zneg, int_start, int_en, iorq_n, m1_n,
        output int_n, int_vector, int_ack, ack_chan, pending
    );

endinterface

// File: rtl/zint_prio.sv
// Fixed-priority encoder: lowest set index of i_req wins.
// o_idx is 0 when nothing is requested.
import zint_pkg::*;

module zint_prio #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_any,
    output logic [2:0]   o_idx
);

    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 3'(i);
        end
    end

endmodule

// File: rtl/zint_mux.sv
// Multi-source Z80 maskable interrupt generator with priority,
// per-channel masks, IM2 vectors and optional sticky pending.
import zint_pkg::*;

module zint_mux #(
    parameter int             NCH      = 4,
    parameter int             INT_LEN  = 128,
    parameter logic [NCH-1:0] STICKY   = '0,
    parameter logic [7:0]     VEC_BASE = 8'hFF
) (
    input  logic      fclk,
    input  logic      rst_n,
    zint_mux_if.slave bus
);

    zstate_t        r_state;
    logic [NCH-1:0] r_pending;
    logic [7:0]     r_cnt;
    logic           r_int_n;
    logic [7:0]     r_vec;
    logic           r_int_ack;
    logic [2:0]     r_ack_chan;

    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_pend_nxt;
    logic           w_any;
    logic [2:0]     w_sel;
    logic           w_ackcond;
    logic           w_ack;
    logic           w_tmo;
    logic [7:0]     w_sel_vec;
    logic           w_unused_zpos;

    assign w_unused_zpos = bus.zpos;

    assign w_req = r_pending & bus.int_en;

    zint_prio #(
        .N (NCH)
    ) u_prio (
        .i_req (w_req),
        .o_any (w_any),
        .o_idx (w_sel)
    );

    assign w_sel_vec = mk_vector(VEC_BASE, w_sel);
    assign w_ackcond = !bus.iorq_n && !bus.m1_n && bus.zneg;

    // Ack beats timeout, timeout beats the req==0 exit.
    assign w_ack = (r_state == ST_ACTIVE) && w_ackcond && w_any;
    assign w_tmo = (r_state == ST_ACTIVE) && !w_ack &&
                   (r_cnt == 8'(INT_LEN - 1));

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            w_clr[i] = (w_ack && (w_sel == 3'(i))) ||
                       (w_tmo && !STICKY[i]);
        end
    end

    // A fresh strobe always wins over a same-cycle clear.
    assign w_pend_nxt = (r_pending & ~w_clr) | bus.int_start;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_cnt      <= '0;
            r_int_n    <= 1'b1;
            r_vec      <= VEC_BASE;
            r_int_ack  <= 1'b0;
            r_ack_chan <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_int_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_int_n <= 1'b1;
                    if (w_any) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= '0;
                        r_int_n <= 1'b0;
                        r_vec   <= w_sel_vec;
                    end
                end
                ST_ACTIVE: begin
                    if (w_ack) begin
                        r_state    <= ST_ACKWAIT;
                        r_int_n    <= 1'b1;
                        r_int_ack  <= 1'b1;
                        r_ack_chan <= w_sel;
                        r_vec      <= w_sel_vec;
                    end else if (w_tmo || !w_any) begin
                        r_state <= ST_IDLE;
                        r_int_n <= 1'b1;
                    end else begin
                        r_int_n <= 1'b0;
                        r_vec   <= w_sel_vec;
                        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_ACKWAIT: begin
                    r_int_n <= 1'b1;
                    if (bus.iorq_n) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_int_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.int_n      = r_int_n;
    assign bus.int_vector = r_vec;
    assign bus.int_ack    = r_int_ack;
    assign bus.ack_chan   = r_ack_chan;
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_zint_mux.sv
// Self-checking bench for zint_mux: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_zint_mux;

    localparam int         NCH      = 4;
    localparam int         INT_LEN  = 128;
    localparam logic [3:0] STICKY   = 4'b0100;
    localparam logic [7:0] VEC_BASE = 8'hFF;

    logic fclk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    zint_mux_if #(.NCH(NCH)) bus ();

    zint_mux #(
        .NCH      (NCH),
        .INT_LEN  (INT_LEN),
        .STICKY   (STICKY),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    typedef struct {
        bit [3:0] pend;
        bit       busy;
        bit       hold;
        bit       ack;
        int       low;
        int       chan;
        bit [7:0] vec;
    } model_t;

    model_t m;

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [7:0] vec_of(input int ch);
        return (VEC_BASE & 8'hF1) | 8'(ch * 2);
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.pend = '0; r.busy = 0; r.hold = 0; r.ack = 0;
        r.low = 0; r.chan = 0; r.vec = VEC_BASE;
        return r;
    endfunction

    // One fclk of the interrupt protocol, in terms of the rules:
    // busy = INT held low, hold = waiting for IORQ to end.
    function automatic model_t step(
        input model_t   c,
        input bit [3:0] st,
        input bit [3:0] en,
        input bit       iorq_n,
        input bit       m1_n,
        input bit       zneg
    );
        model_t   n;
        bit [3:0] newp;
        int       s;
        bit       inta;
        n    = c;
        n.ack = 0;
        newp = c.pend;
        s    = lowest(c.pend & en);
        inta = !iorq_n && !m1_n && zneg;
        if (c.hold) begin
            if (iorq_n) n.hold = 0;
        end else if (!c.busy) begin
            if (s >= 0) begin
                n.busy = 1; n.low = 1; n.vec = vec_of(s);
            end
        end else if (inta && s >= 0) begin
            newp[s] = 1'b0;
            n.ack = 1; n.chan = s; n.vec = vec_of(s);
            n.busy = 0; n.hold = 1;
        end else if (c.low == INT_LEN) begin
            newp = newp & STICKY;
            n.busy = 0;
        end else if (s < 0) begin
            n.busy = 0;
        end else begin
            n.low = c.low + 1;
            n.vec = vec_of(s);
        end
        n.pend = newp | st;
        return n;
    endfunction

    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else m <= step(m, bus.int_start, bus.int_en,
                       bus.iorq_n, bus.m1_n, bus.zneg);
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge fclk) begin
        chk("m_int_n", 32'(bus.int_n), 32'(!m.busy));
        chk("m_vector", 32'(bus.int_vector), 32'(m.vec));
        chk("m_int_ack", 32'(bus.int_ack), 32'(m.ack));
        chk("m_ack_chan", 32'(bus.ack_chan), 32'(3'(m.chan)));
        chk("m_pending", 32'(bus.pending), 32'(m.pend));
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (bus.int_n === 1'b0 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic do_ack(input int exp_ch, input logic [3:0] st);
        bus.iorq_n    = 1'b0;
        bus.m1_n      = 1'b0;
        bus.zneg      = 1'b1;
        bus.int_start = st;
        tick();
        bus.zneg      = 1'b0;
        bus.int_start = '0;
        chk("ack_pulse", 32'(bus.int_ack), 32'd1);
        chk("ack_chan", 32'(bus.ack_chan), 32'(exp_ch));
        chk("ack_vec", 32'(bus.int_vector), 32'(vec_of(exp_ch)));
        chk("ack_int_n", 32'(bus.int_n), 32'd1);
        tick();
        chk("ackwait_noack", 32'(bus.int_ack), 32'd0);
        chk("ackwait_int_n", 32'(bus.int_n), 32'd1);
        bus.iorq_n = 1'b1;
        bus.m1_n   = 1'b1;
        tick();
    endtask

    int n;

    initial begin
        rst_n         = 1'b1;
        bus.zpos      = 1'b0;
        bus.zneg      = 1'b0;
        bus.int_start = '0;
        bus.int_en    = 4'hF;
        bus.iorq_n    = 1'b1;
        bus.m1_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_int_n", 32'(bus.int_n), 32'd1);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_vector", 32'(bus.int_vector), 32'hFF);
        chk("rst_ack", 32'(bus.int_ack), 32'd0);
        chk("rst_chan", 32'(bus.ack_chan), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single non-sticky source, timeout
        bus.int_start = 4'b0001;
        tick();
        bus.int_start = '0;
        chk("frame_pend", 32'(bus.pending), 32'h1);
        chk("frame_hi", 32'(bus.int_n), 32'd1);
        tick();
        chk("frame_lo", 32'(bus.int_n), 32'd0);
        chk("frame_vec", 32'(bus.int_vector), 32'hF1);
        count_low(n);
        chk("frame_len", 32'(n), 32'd128);
        chk("frame_clr", 32'(bus.pending), 32'h0);
        tick();
        chk("frame_idle", 32'(bus.int_n), 32'd1);

        // Priority between channels 1 and 2
        bus.int_start = 4'b0110;
        tick();
        bus.int_start = '0;
        tick();
        chk("prio_lo", 32'(bus.int_n), 32'd0);
        chk("prio_vec", 32'(bus.int_vector), 32'hF3);
        do_ack(1, 4'b0000);
        chk("prio_pend", 32'(bus.pending), 32'h4);
        n = 0;
        while (bus.int_n !== 1'b0 && n < 2) begin
            tick();
            n++;
        end
        chk("prio_reassert", 32'(bus.int_n), 32'd0);
        chk("prio_vec2", 32'(bus.int_vector), 32'hF5);
        do_ack(2, 4'b0000);
        chk("prio_pend2", 32'(bus.pending), 32'h0);

        // Sticky channel 2 survives timeout
        bus.int_start = 4'b0100;
        tick();
        bus.int_start = '0;
        tick();
        count_low(n);
        chk("sticky_len", 32'(n), 32'd128);
        chk("sticky_pend", 32'(bus.pending), 32'h4);
        chk("sticky_gap", 32'(bus.int_n), 32'd1);
        tick();
        chk("sticky_again", 32'(bus.int_n), 32'd0);
        do_ack(2, 4'b0000);
        chk("sticky_clr", 32'(bus.pending), 32'h0);

        // Mask on channel 3
        bus.int_en    = 4'b0111;
        bus.int_start = 4'b1000;
        tick();
        bus.int_start = '0;
        tick();
        tick();
        chk("mask_hi", 32'(bus.int_n), 32'd1);
        chk("mask_pend", 32'(bus.pending), 32'h8);
        bus.int_en = 4'hF;
        tick();
        chk("mask_lo", 32'(bus.int_n), 32'd0);
        chk("mask_vec", 32'(bus.int_vector), 32'hF7);
        bus.int_en = 4'b0111;
        tick();
        chk("mask_drop", 32'(bus.int_n), 32'd1);
        chk("mask_keep", 32'(bus.pending), 32'h8);
        bus.int_en = 4'hF;
        tick();
        do_ack(3, 4'b0000);

        // New event on channel 0 during its own ack
        bus.int_start = 4'b0001;
        tick();
        bus.int_start = '0;
        tick();
        do_ack(0, 4'b0001);
        chk("coll_pend", 32'(bus.pending), 32'h1);
        tick();
        chk("coll_reassert", 32'(bus.int_n), 32'd0);
        do_ack(0, 4'b0000);

        // Asynchronous reset mid-assertion
        bus.int_start = 4'b1011;
        tick();
        bus.int_start = '0;
        tick();
        chk("rst2_lo", 32'(bus.int_n), 32'd0);
        chk("rst2_pend", 32'(bus.pending), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_int_n", 32'(bus.int_n), 32'd1);
        chk("rst2_pending", 32'(bus.pending), 32'h0);
        chk("rst2_vector", 32'(bus.int_vector), 32'hFF);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic; odd segments never acknowledge
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 500; c++) begin
                logic [3:0] st;
                int         k;
                for (int b = 0; b < NCH; b++)
                    st[b] = ($urandom_range(19) == 0);
                bus.int_start = st;
                if ($urandom_range(29) == 0) begin
                    k = int'($urandom_range(3));
                    bus.int_en[k] = ~bus.int_en[k];
                end
                if (seg % 2 == 0) begin
                    bus.iorq_n = ($urandom_range(3) != 0);
                    bus.m1_n   = 1'($urandom_range(1));
                    bus.zneg   = 1'($urandom_range(1));
                end else begin
                    bus.iorq_n = 1'b1;
                    bus.m1_n   = 1'b1;
                    bus.zneg   = 1'b0;
                end
                bus.zpos = 1'($urandom_range(1));
                tick();
            end
        end
        bus.int_start = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
